// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder slice.
// Holds the immediate-type codes (shared with the immediate generator and
// the control unit), the stage-0 payload record and a sign-extension check.
package imm_encoder_pkg;

  localparam int unsigned IMM_TYPE_W = 3;

  localparam logic [IMM_TYPE_W-1:0] IMM_I  = 3'd0;
  localparam logic [IMM_TYPE_W-1:0] IMM_S  = 3'd1;
  localparam logic [IMM_TYPE_W-1:0] IMM_B  = 3'd2;
  localparam logic [IMM_TYPE_W-1:0] IMM_U  = 3'd3;
  localparam logic [IMM_TYPE_W-1:0] IMM_J  = 3'd4;
  localparam logic [IMM_TYPE_W-1:0] IMM_IV = 3'd5;

  typedef struct packed {
    logic [IMM_TYPE_W-1:0] imm_type;
    logic [31:0]           imm;
    logic [31:0]           inst;
    logic                  err;
  } s0_t;

  // True when v[31:msb] is neither all zeros nor all ones, i.e. v is not the
  // sign extension of its low (msb) bits plus one sign bit.
  function automatic logic not_sext(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = '1 << msb;
    return ((v & m) != '0) && ((v & m) != m);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Stream bundle for the immediate encoder.
// istream_*: val/rdy input carrying immediate type, immediate and template.
// ostream_*: val/rdy output carrying the encoded instruction and error flag.
// master = producer of istream / consumer of ostream; slave = the encoder.
interface imm_encoder_if;
  import imm_encoder_pkg::*;

  logic                  istream_val;
  logic                  istream_rdy;
  logic [IMM_TYPE_W-1:0] istream_imm_type;
  logic [31:0]           istream_imm;
  logic [31:0]           istream_inst;
  logic                  ostream_val;
  logic                  ostream_rdy;
  logic [31:0]           ostream_inst;
  logic                  ostream_err;

  modport master (
    output istream_val, istream_imm_type, istream_imm, istream_inst, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_inst, ostream_err
  );

  modport slave (
    input  istream_val, istream_imm_type, istream_imm, istream_inst, ostream_rdy,
    output istream_rdy, ostream_val, ostream_inst, ostream_err
  );

endinterface

// File: rtl/imm_encoder_imm_pack.sv
// Combinational field packer: places an immediate into the immediate fields
// of an instruction template for the given format; all other bits pass through.
// Ports: i_imm_type (format), i_imm (value), i_inst (template), o_inst (packed).
// Unknown formats return the template unchanged.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [IMM_TYPE_W-1:0] i_imm_type,
  input  logic [31:0]           i_imm,
  input  logic [31:0]           i_inst,
  output logic [31:0]           o_inst
);

  always_comb begin
    o_inst = i_inst;
    case (i_imm_type)
      IMM_I: o_inst[31:20] = i_imm[11:0];
      IMM_S: begin
        o_inst[31:25] = i_imm[11:5];
        o_inst[11:7]  = i_imm[4:0];
      end
      IMM_B: begin
        o_inst[31]    = i_imm[12];
        o_inst[7]     = i_imm[11];
        o_inst[30:25] = i_imm[10:5];
        o_inst[11:8]  = i_imm[4:1];
      end
      IMM_U: o_inst[31:12] = i_imm[31:12];
      IMM_J: begin
        o_inst[31]    = i_imm[20];
        o_inst[19:12] = i_imm[19:12];
        o_inst[20]    = i_imm[11];
        o_inst[30:21] = i_imm[10:1];
      end
      IMM_IV: o_inst[24:20] = i_imm[4:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: two-stage val/rdy pipeline that packs a 32-bit immediate
// into an instruction template. Stage 0 registers the request together with
// a representability check; stage 1 packs the fields (or passes the template
// through on error) and drives the output stream.
// Ports: clk, reset (sync, active-high), bus (imm_encoder_if.slave),
//        err_count (saturating count of errored output transfers).
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  imm_encoder_if.slave           bus,
  output logic [p_cnt_nbits-1:0] err_count
);

  localparam logic [p_cnt_nbits-1:0] CNT_ONE = 1;

  logic                   r_s0_val;
  s0_t                    r_s0;
  logic                   r_s1_val;
  logic [31:0]            r_s1_inst;
  logic                   r_s1_err;
  logic [p_cnt_nbits-1:0] r_err_count;

  logic                   w_s1_go;
  logic                   w_s0_go;
  logic                   w_in_err;
  logic [31:0]            w_packed;

  assign w_s1_go = !r_s1_val || bus.ostream_rdy;
  assign w_s0_go = !r_s0_val || w_s1_go;

  assign bus.istream_rdy  = w_s0_go;
  assign bus.ostream_val  = r_s1_val;
  assign bus.ostream_inst = r_s1_inst;
  assign bus.ostream_err  = r_s1_err;
  assign err_count        = r_err_count;

  // Range check on the incoming immediate; result travels with the item.
  always_comb begin
    w_in_err = 1'b1;
    case (bus.istream_imm_type)
      IMM_I, IMM_S: w_in_err = not_sext(bus.istream_imm, 11);
      IMM_B:        w_in_err = not_sext(bus.istream_imm, 12) || bus.istream_imm[0];
      IMM_U:        w_in_err = (bus.istream_imm[11:0] != '0);
      IMM_J:        w_in_err = not_sext(bus.istream_imm, 20) || bus.istream_imm[0];
      IMM_IV:       w_in_err = not_sext(bus.istream_imm, 4);
      default:      w_in_err = 1'b1;
    endcase
  end

  imm_pack u_pack (
    .i_imm_type (r_s0.imm_type),
    .i_imm      (r_s0.imm),
    .i_inst     (r_s0.inst),
    .o_inst     (w_packed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_val    <= 1'b0;
      r_s1_val    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_s0_go) r_s0_val <= bus.istream_val;
      if (w_s1_go) r_s1_val <= r_s0_val;
      if (r_s1_val && bus.ostream_rdy && r_s1_err && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_ONE;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_s0_go && bus.istream_val) begin
      r_s0.imm_type <= bus.istream_imm_type;
      r_s0.imm      <= bus.istream_imm;
      r_s0.inst     <= bus.istream_inst;
      r_s0.err      <= w_in_err;
    end
    if (w_s1_go && r_s0_val) begin
      r_s1_inst <= r_s0.err ? r_s0.inst : w_packed;
      r_s1_err  <= r_s0.err;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] err_count;

  imm_encoder_if bus();

  imm_encoder #(.p_cnt_nbits(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] tmpl;
    bit          has_exp;
    logic [31:0] exp_inst;
    logic        exp_err;
  } item_t;

  item_t       sb[$];
  item_t       cur;
  int          checks = 0;
  int          errors = 0;
  int unsigned model_cnt = 0;
  bit          accepted = 0;
  bit          hold_prev = 0;
  logic [31:0] hold_inst;
  logic        hold_err;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic item_t mk(logic [2:0] t, logic [31:0] imm, logic [31:0] tmpl,
                               bit has_exp, logic [31:0] ei, logic ee);
    item_t it;
    it.t = t; it.imm = imm; it.tmpl = tmpl;
    it.has_exp = has_exp; it.exp_inst = ei; it.exp_err = ee;
    return it;
  endfunction

  // Representability by numeric range rather than bit patterns.
  function automatic logic model_err(logic [2:0] t, logic [31:0] imm);
    logic signed [31:0] s;
    s = imm;
    case (t)
      3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
      3'd2:       return !(s >= -4096 && s <= 4095) || imm[0];
      3'd3:       return imm[11:0] != 12'd0;
      3'd4:       return !(s >= -1048576 && s <= 1048575) || imm[0];
      3'd5:       return !(s >= -16 && s <= 15);
      default:    return 1'b1;
    endcase
  endfunction

  // Immediate generator (decoder side of the datapath).
  function automatic logic [31:0] decode(logic [2:0] t, logic [31:0] i);
    case (t)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {i[31:12], 12'd0};
      3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: return {{27{i[24]}}, i[24:20]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(logic [2:0] t);
    case (t)
      3'd0: return 32'hFFF0_0000;
      3'd1, 3'd2: return 32'hFE00_0F80;
      3'd3, 3'd4: return 32'hFFFF_F000;
      3'd5: return 32'h01F0_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic void pop_check();
    item_t       e;
    logic        ee;
    logic [31:0] m;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output: got inst 0x%08h with nothing expected", bus.ostream_inst);
      return;
    end
    e  = sb.pop_front();
    ee = e.has_exp ? e.exp_err : model_err(e.t, e.imm);
    chk("err", {31'd0, bus.ostream_err}, {31'd0, ee});
    if (ee) begin
      chk("err_passthru", bus.ostream_inst, e.tmpl);
      if (model_cnt != 32'hFFFF) model_cnt++;
    end else begin
      m = imm_mask(e.t);
      chk("roundtrip", decode(e.t, bus.ostream_inst), e.imm);
      chk("template_bits", bus.ostream_inst & ~m, e.tmpl & ~m);
    end
    if (e.has_exp) chk("inst", bus.ostream_inst, e.exp_inst);
  endfunction

  // One clock: entered just after a negedge with inputs already driven.
  task automatic step();
    #1;
    chk("err_count", {16'd0, err_count}, model_cnt);
    if (hold_prev) begin
      chk("hold_val", {31'd0, bus.ostream_val}, 32'd1);
      chk("hold_inst", bus.ostream_inst, hold_inst);
      chk("hold_err", {31'd0, bus.ostream_err}, {31'd0, hold_err});
    end
    hold_prev = bus.ostream_val && !bus.ostream_rdy;
    hold_inst = bus.ostream_inst;
    hold_err  = bus.ostream_err;
    if (bus.ostream_val && bus.ostream_rdy) pop_check();
    accepted = bus.istream_val && bus.istream_rdy;
    if (accepted) sb.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(item_t it);
    cur = it;
    bus.istream_imm_type = it.t;
    bus.istream_imm      = it.imm;
    bus.istream_inst     = it.tmpl;
    bus.istream_val      = 1'b1;
  endtask

  task automatic drive(item_t it);
    present(it);
    for (int i = 0; i < 200; i++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got istream_rdy low for 200 cycles expected accept");
    end
  endtask

  task automatic drain();
    bus.istream_val = 1'b0;
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d items pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_cnt = 0;
    hold_prev = 0;
    #1;
    chk("rst_oval", {31'd0, bus.ostream_val}, 32'd0);
    chk("rst_irdy", {31'd0, bus.istream_rdy}, 32'd1);
    chk("rst_cnt", {16'd0, err_count}, 32'd0);
  endtask

  item_t       vec[$];
  item_t       bp[4];
  int          idx;
  logic [31:0] r;
  logic [31:0] imm;

  initial begin
    reset = 1'b1;
    bus.istream_val = 1'b0;
    bus.istream_imm_type = '0;
    bus.istream_imm = '0;
    bus.istream_inst = '0;
    bus.ostream_rdy = 1'b1;
    @(negedge clk);
    do_reset();

    // Latency: accepted at edge N, visible after edge N+1.
    present(mk(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 1, 32'hFFF0_0013, 0));
    step();
    bus.istream_val = 1'b0;
    #1 chk("lat_n", {31'd0, bus.ostream_val}, 32'd0);
    step();
    #1 chk("lat_n1", {31'd0, bus.ostream_val}, 32'd1);
    drain();

    vec.push_back(mk(IMM_B,  32'h0000_0FFE, 32'h0000_0063, 1, 32'h7E00_0FE3, 0));
    vec.push_back(mk(IMM_B,  32'h0000_0FFF, 32'h0000_0063, 1, 32'h0000_0063, 1));
    vec.push_back(mk(IMM_U,  32'h1234_5001, 32'h0000_0037, 1, 32'h0000_0037, 1));
    vec.push_back(mk(IMM_J,  32'h0010_0000, 32'h0000_006F, 1, 32'h0000_006F, 1));
    vec.push_back(mk(3'd7,   32'h0000_0000, 32'h0000_0013, 1, 32'h0000_0013, 1));
    vec.push_back(mk(IMM_S,  32'hFFFF_F800, 32'h0000_2023, 1, 32'h8000_2023, 0));
    vec.push_back(mk(IMM_U,  32'hABCD_E000, 32'h0000_0537, 1, 32'hABCD_E537, 0));
    vec.push_back(mk(IMM_J,  32'hFFFF_FFFE, 32'h0000_00EF, 1, 32'hFFFF_F0EF, 0));
    vec.push_back(mk(IMM_IV, 32'hFFFF_FFF0, 32'h4000_5013, 1, 32'h4100_5013, 0));
    vec.push_back(mk(IMM_IV, 32'h0000_0010, 32'h4000_5013, 1, 32'h4000_5013, 1));
    vec.push_back(mk(IMM_I,  32'h0000_0800, 32'h0000_0013, 1, 32'h0000_0013, 1));
    vec.push_back(mk(IMM_I,  32'h0000_07FF, 32'h00A0_0093, 1, 32'h7FF0_0093, 0));
    vec.push_back(mk(3'd6,   32'h0000_0004, 32'h0000_0013, 1, 32'h0000_0013, 1));
    for (int i = 0; i < vec.size(); i++) drive(vec[i]);
    drain();
    step();
    #1 chk("table_err_count", {16'd0, err_count}, 32'd7);

    // Backpressure: output stalled for 5 cycles while 4 items are offered.
    for (int i = 0; i < 4; i++)
      bp[i] = mk(IMM_I, 32'd100 + 32'(i), 32'h0000_0013 + (32'(i) << 7), 0, 0, 0);
    idx = 0;
    bus.ostream_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      present(bp[idx]);
      step();
      if (accepted) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    #1 chk("bp_irdy_low", {31'd0, bus.istream_rdy}, 32'd0);
    bus.ostream_rdy = 1'b1;
    while (idx < 4) begin
      present(bp[idx]);
      step();
      chk("bp_resume", {31'd0, accepted}, 32'd1);
      if (accepted) idx++;
      else idx = 4;
    end
    drain();

    // Random round trip with random backpressure and idle gaps.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = {{20{r[11]}}, r[11:1], 1'b0};
        2: imm = {{11{r[20]}}, r[20:1], 1'b0};
        default: imm = r & 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 5) == 0) imm = {{27{r[4]}}, r[4:0]};
      present(mk(3'($urandom_range(0, 5)), imm, $urandom, 0, 0, 0));
      for (int k = 0; k < 100; k++) begin
        bus.ostream_rdy = ($urandom_range(0, 3) != 0);
        step();
        if (accepted) break;
      end
      if (!accepted) begin
        checks++;
        errors++;
        $display("FAIL rand_accept_timeout: got no accept expected accept");
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.istream_val = 1'b0;
        step();
      end
    end
    drain();

    // Counter saturation: 65536 errored transfers.
    do_reset();
    bus.ostream_rdy = 1'b1;
    for (int n = 0; n < 65536; n++) drive(mk(3'd7, 32'(n), 32'h0000_0013, 1, 32'h0000_0013, 1));
    drain();
    step();
    #1 chk("sat_count", {16'd0, err_count}, 32'h0000_FFFF);

    // Reset with two items in flight discards them.
    bus.ostream_rdy = 1'b0;
    drive(mk(3'd7, 32'd1, 32'h0000_0013, 1, 32'h0000_0013, 1));
    drive(mk(IMM_I, 32'd5, 32'h0000_0013, 1, 32'h0050_0013, 0));
    bus.istream_val = 1'b0;
    step();
    do_reset();
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      #1 chk("post_rst_no_out", {31'd0, bus.ostream_val}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
